ififo_1r1w1ck_fwft: RTL and testbench



---
 rtl/ififo_1r1w1ck_fwft_pkg.sv | 8 +
 rtl/iram_1r1w1ck_p.sv | 29 ++
 rtl/ififo_1r1w1ck_fwft.sv | 115 +++++++++++
 tb/tb_ififo_1r1w1ck_fwft.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ififo_1r1w1ck_fwft_pkg.sv
// Shared defaults for the show-ahead FIFO and its BRAM.
// The FIFO stays generic, so this package only holds the default geometry.
package ififo_1r1w1ck_fwft_pkg;

  localparam int unsigned IFIFO_DEF_WIDTH = 518;
  localparam int unsigned IFIFO_DEF_DEPTH = 64;

endpackage

// File: rtl/iram_1r1w1ck_p.sv
// Simple dual-port block RAM: one write port (A) and one registered read port (B) on one clock.
// The array and dob have no reset, so synthesis can map them onto a BRAM primitive.
module iram_1r1w1ck_p #(
  parameter int unsigned WIDTH = 518,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             ena,
  input  logic             enb,
  input  logic             wea,
  input  logic [AW-1:0]    addra,
  input  logic [AW-1:0]    addrb,
  input  logic [WIDTH-1:0] dia,
  output logic [WIDTH-1:0] dob
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem[addra] <= dia;
    end
    if (enb) begin
      dob <= mem[addrb];
    end
  end

endmodule

// File: rtl/ififo_1r1w1ck_fwft.sv
// Show-ahead FIFO: DEPTH entries in BRAM plus the RAM output register as a head slot (DEPTH+1 total).
// The head is prefetched whenever the output slot is empty or is being popped.
module ififo_1r1w1ck_fwft
  import ififo_1r1w1ck_fwft_pkg::*;
#(
  parameter int unsigned WIDTH = IFIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = IFIFO_DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [AW:0]      level,
  output logic             wr_ovf
);

  localparam logic [AW:0] RAM_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          wr_ovf_q, wr_ovf_d;

  logic kill;
  logic pop;
  logic wr_acc;
  logic rd_en;

  // Flush and reset cancel both the RAM write and the prefetch of this cycle.
  always_comb begin
    kill   = flush | reset;
    pop    = out_valid_q & rd_ready;
    wr_acc = wr_valid & wr_ready & ~kill;
    rd_en  = (ram_cnt_q != '0) & (~out_valid_q | pop) & ~kill;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    out_valid_d = out_valid_q;
    wr_ovf_d    = wr_ovf_q | (wr_valid & ~wr_ready);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_acc, rd_en})
      2'b10:   ram_cnt_d = ram_cnt_q + (AW+1)'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - (AW+1)'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    // The sticky overflow flag survives a flush; only reset clears it.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_cnt_d   = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      wr_ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
      wr_ovf_q    <= wr_ovf_d;
    end
  end

  assign wr_ready = (ram_cnt_q != RAM_FULL);
  assign rd_valid = out_valid_q;
  assign level    = ram_cnt_q + {{AW{1'b0}}, out_valid_q};
  assign wr_ovf   = wr_ovf_q;

  iram_1r1w1ck_p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .ena   (wr_acc),
    .enb   (rd_en),
    .wea   (wr_acc),
    .addra (wr_ptr_q),
    .addrb (rd_ptr_q),
    .dia   (wr_data),
    .dob   (rd_data)
  );

endmodule

// File: tb/tb_ififo_1r1w1ck_fwft.sv
// Directed bench for the show-ahead FIFO at its default 518x64 geometry.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ififo_1r1w1ck_fwft;

  localparam int WIDTH = 518;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready;
  logic [AW:0]      level;
  logic             wr_ovf;

  int n_checks;
  int n_fail;

  ififo_1r1w1ck_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .level    (level),
    .wr_ovf   (wr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (wr_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_ovf: got %b expected 0", wr_ovf); end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1; wr_data = WIDTH'(12'h2A5); rd_ready = 1'b0;
    tick();
    wr_valid = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_t1_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (level !== 7'd1) begin n_fail++; $display("[TB] FAIL single_t1_level: got %0d expected 1", level); end
    tick();
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_t2_rd_valid: got %b expected 1", rd_valid); end
    n_checks++; if (rd_data !== WIDTH'(12'h2A5)) begin n_fail++; $display("[TB] FAIL single_rd_data: got %h expected 2a5", rd_data); end
    n_checks++; if (level !== 7'd1) begin n_fail++; $display("[TB] FAIL single_t2_level: got %0d expected 1", level); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_pop_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL single_pop_level: got %0d expected 0", level); end
  endtask

  task automatic test_fill_overflow();
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_valid = 1'b1; wr_data = WIDTH'(i);
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_wr_ready[%0d]: got %b expected 1", i, wr_ready); end
      tick();
    end
    wr_valid = 1'b0;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_wr_ready: got %b expected 0", wr_ready); end
    n_checks++; if (level !== 7'd65) begin n_fail++; $display("[TB] FAIL full_level: got %0d expected 65", level); end
    n_checks++; if (wr_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL full_wr_ovf_early: got %b expected 0", wr_ovf); end
    wr_valid = 1'b1; wr_data = WIDTH'(16'hEEEE);
    tick();
    wr_valid = 1'b0;
    n_checks++; if (wr_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", wr_ovf); end
    n_checks++; if (level !== 7'd65) begin n_fail++; $display("[TB] FAIL ovf_level: got %0d expected 65", level); end
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_rd_valid[%0d]: got %b expected 1", i, rd_valid); end
      n_checks++; if (rd_data !== WIDTH'(i)) begin n_fail++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, rd_data, WIDTH'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drained_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL drained_level: got %0d expected 0", level); end
    n_checks++; if (wr_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", wr_ovf); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 300; cyc++) begin
      wr_valid = (sent < 300);
      wr_data  = WIDTH'(1000 + sent);
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_wr_ready[%0d]: got %b expected 1", cyc, wr_ready); end
      n_checks++; if (level > 7'd2) begin n_fail++; $display("[TB] FAIL b2b_level[%0d]: got %0d expected <=2", cyc, level); end
      if (rd_valid === 1'b1) begin
        n_checks++; if (rd_data !== WIDTH'(1000 + got)) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", got, rd_data, WIDTH'(1000 + got)); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (wr_valid && wr_ready === 1'b1) sent++;
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    n_checks++; if (got !== 300) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 300", got); end
    n_checks++; if (first !== 2) begin n_fail++; $display("[TB] FAIL b2b_first_cycle: got %0d expected 2", first); end
    n_checks++; if (last - first !== 299) begin n_fail++; $display("[TB] FAIL b2b_span: got %0d expected 299", last - first); end
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL b2b_end_level: got %0d expected 0", level); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_d;
    int ram_m = 0;
    bit ov_m = 0;
    int seq = 0;
    bit wv, rr, pop_m, rden_m, acc_m;
    for (int cyc = 0; cyc < 5300; cyc++) begin
      if (cyc < 5000) begin
        wv = ($urandom_range(99) < 50);
        rr = ($urandom_range(99) < 30);
      end else begin
        wv = 1'b0;
        rr = 1'b1;
      end
      wr_valid = wv; rd_ready = rr; wr_data = WIDTH'(32'h4000_0000 + seq);
      n_checks++; if (wr_ready !== (ram_m != DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_wr_ready[%0d]: got %b expected %b", cyc, wr_ready, ram_m != DEPTH); end
      n_checks++; if (rd_valid !== ov_m) begin n_fail++; $display("[TB] FAIL rnd_rd_valid[%0d]: got %b expected %b", cyc, rd_valid, ov_m); end
      n_checks++; if (level !== (AW+1)'(q.size())) begin n_fail++; $display("[TB] FAIL rnd_level[%0d]: got %0d expected %0d", cyc, level, q.size()); end
      pop_m  = ov_m && rr;
      rden_m = (ram_m != 0) && (!ov_m || pop_m);
      acc_m  = wv && (ram_m != DEPTH);
      if (pop_m) begin
        exp_d = q.pop_front();
        n_checks++; if (rd_data !== exp_d) begin n_fail++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", cyc, rd_data, exp_d); end
      end
      if (acc_m) begin
        q.push_back(WIDTH'(32'h4000_0000 + seq));
        seq++;
      end
      ram_m = ram_m + int'(acc_m) - int'(rden_m);
      if (rden_m) ov_m = 1'b1;
      else if (pop_m) ov_m = 1'b0;
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_checks++; if (q.size() != 0 || level !== 7'd0) begin n_fail++; $display("[TB] FAIL rnd_drain: got level %0d model %0d expected 0", level, q.size()); end
  endtask

  task automatic test_flush();
    int waited = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_data = WIDTH'(16'hA000 + i);
      tick();
    end
    n_checks++; if (level !== 7'd10) begin n_fail++; $display("[TB] FAIL flush_pre_level: got %0d expected 10", level); end
    flush = 1'b1; wr_valid = 1'b1; wr_data = WIDTH'(16'hDEAD); rd_ready = 1'b1;
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL flush_level: got %0d expected 0", level); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (wr_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_keeps_ovf: got %b expected 1", wr_ovf); end
    wr_valid = 1'b1; wr_data = WIDTH'(12'h111);
    tick();
    wr_valid = 1'b0;
    while (rd_valid !== 1'b1 && waited < 5) begin tick(); waited++; end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_new_valid: got %b expected 1", rd_valid); end
    n_checks++; if (rd_data !== WIDTH'(12'h111)) begin n_fail++; $display("[TB] FAIL flush_new_data: got %h expected 111", rd_data); end
    n_checks++; if (level !== 7'd1) begin n_fail++; $display("[TB] FAIL flush_new_level: got %0d expected 1", level); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL flush_end_level: got %0d expected 0", level); end
  endtask

  task automatic test_reset_midstream();
    int waited = 0;
    int stale = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = WIDTH'(16'hBAD0 + i);
      tick();
    end
    wr_valid = 1'b0;
    n_checks++; if (level !== 7'd5 || wr_ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre: got level %0d ovf %b expected level 5 ovf 1", level, wr_ovf); end
    reset = 1'b1; wr_valid = 1'b1; wr_data = WIDTH'(16'hBADF); rd_ready = 1'b1;
    tick();
    reset = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    n_checks++; if (wr_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wr_ovf: got %b expected 0", wr_ovf); end
    n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL rst_level: got %0d expected 0", level); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_wr_ready: got %b expected 1", wr_ready); end
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rd_valid !== 1'b0) stale++;
      tick();
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("[TB] FAIL rst_stale_cycles: got %0d expected 0", stale); end
    rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = WIDTH'(12'h5A5);
    tick();
    wr_valid = 1'b0;
    while (rd_valid !== 1'b1 && waited < 5) begin tick(); waited++; end
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== WIDTH'(12'h5A5)) begin n_fail++; $display("[TB] FAIL rst_next_word: got valid %b data %h expected valid 1 data 5a5", rd_valid, rd_data); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
